// File: rtl/result_display.sv
// result_display: 16-bit word shown in decimal on a 5-digit muxed 7-seg display.
// Define RESULT_DISPLAY_SIGNED_EN to treat the word as two's complement.
module result_display #(
   parameter int unsigned SCAN_DIV = 50000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [15:0] value,
   output logic [6:0]  seg,
   output logic [4:0]  anode,
   output logic        negative,
   output logic        busy
);
   localparam logic [0:0]  S_IDLE   = 1'b0;
   localparam logic [0:0]  S_CONV   = 1'b1;
   localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);

   logic [0:0]  r_state;
   logic [15:0] r_captured;
   logic [15:0] r_shift;
   logic [19:0] r_bcd;
   logic [19:0] r_digits;
   logic [3:0]  r_step;
   logic        r_busy;
   logic [15:0] r_div_cnt;
   logic [2:0]  r_scan_idx;
   logic [6:0]  r_seg;
   logic [4:0]  r_anode;

   logic [19:0] w_adj;
   logic [35:0] w_next;
   logic [15:0] w_load;
   logic        w_start;
   logic        w_latch;
   logic [4:0]  w_blank;
   logic [3:0]  w_digit;
   logic        w_dblank;

   function automatic logic [6:0] seg_code(input logic [3:0] d);
      case (d)
         4'd0:    seg_code = 7'b1000000;
         4'd1:    seg_code = 7'b1111001;
         4'd2:    seg_code = 7'b0100100;
         4'd3:    seg_code = 7'b0110000;
         4'd4:    seg_code = 7'b0011001;
         4'd5:    seg_code = 7'b0010010;
         4'd6:    seg_code = 7'b0000010;
         4'd7:    seg_code = 7'b1111000;
         4'd8:    seg_code = 7'b0000000;
         4'd9:    seg_code = 7'b0010000;
         default: seg_code = 7'b1111111;
      endcase
   endfunction

   assign w_start = (r_state == S_IDLE) && (value != r_captured);
   assign w_latch = (r_state == S_CONV) && (r_step == 4'd15);

`ifdef RESULT_DISPLAY_SIGNED_EN
   logic r_sign;
   logic r_negative;

   assign w_load   = value[15] ? (~value + 16'd1) : value;
   assign negative = r_negative;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_sign     <= 1'b0;
         r_negative <= 1'b0;
      end else begin
         if (w_start) r_sign <= value[15];
         if (w_latch) r_negative <= r_sign;
      end
   end
`else
   assign w_load   = value;
   assign negative = 1'b0;
`endif

   // Double-dabble step: correct nibbles >= 5, then shift one bit in
   always_comb begin
      w_adj = r_bcd;
      for (int i = 0; i < 5; i++) begin
         if (r_bcd[i*4 +: 4] >= 4'd5)
            w_adj[i*4 +: 4] = r_bcd[i*4 +: 4] + 4'd3;
      end
      w_next = {w_adj, r_shift} << 1;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_captured <= '0;
         r_shift    <= '0;
         r_bcd      <= '0;
         r_step     <= '0;
         r_digits   <= '0;
         r_busy     <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_start) begin
                  r_captured <= value;
                  r_shift    <= w_load;
                  r_bcd      <= '0;
                  r_step     <= '0;
                  r_busy     <= 1'b1;
                  r_state    <= S_CONV;
               end
            end
            S_CONV: begin
               r_bcd   <= w_next[35:16];
               r_shift <= w_next[15:0];
               r_step  <= r_step + 4'd1;
               if (w_latch) begin
                  r_digits <= w_next[35:16];
                  r_busy   <= 1'b0;
                  r_state  <= S_IDLE;
               end
            end
         endcase
      end
   end

   // Digit k blanks when it and all higher digits are zero
   always_comb begin
      w_blank[4] = (r_digits[19:16] == 4'd0);
      w_blank[3] = w_blank[4] && (r_digits[15:12] == 4'd0);
      w_blank[2] = w_blank[3] && (r_digits[11:8] == 4'd0);
      w_blank[1] = w_blank[2] && (r_digits[7:4] == 4'd0);
      w_blank[0] = 1'b0;
   end

   always_comb begin
      w_digit  = r_digits[3:0];
      w_dblank = w_blank[0];
      case (r_scan_idx)
         3'd1: begin w_digit = r_digits[7:4];   w_dblank = w_blank[1]; end
         3'd2: begin w_digit = r_digits[11:8];  w_dblank = w_blank[2]; end
         3'd3: begin w_digit = r_digits[15:12]; w_dblank = w_blank[3]; end
         3'd4: begin w_digit = r_digits[19:16]; w_dblank = w_blank[4]; end
         default: ;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_div_cnt  <= '0;
         r_scan_idx <= '0;
         r_seg      <= 7'b1111111;
         r_anode    <= 5'b11111;
      end else begin
         if (r_div_cnt == DIV_LAST) begin
            r_div_cnt  <= '0;
            r_scan_idx <= (r_scan_idx == 3'd4) ? 3'd0 : r_scan_idx + 3'd1;
         end else begin
            r_div_cnt <= r_div_cnt + 16'd1;
         end
         r_anode <= ~(5'b00001 << r_scan_idx);
         r_seg   <= w_dblank ? 7'b1111111 : seg_code(w_digit);
      end
   end

   assign seg   = r_seg;
   assign anode = r_anode;
   assign busy  = r_busy;

endmodule

// File: tb/tb_result_display.sv
// Directed bench for result_display with SCAN_DIV=4.
// Expected segment patterns are hand-derived per test value.
module tb_result_display;
   localparam logic [6:0] S0 = 7'b1000000;
   localparam logic [6:0] S1 = 7'b1111001;
   localparam logic [6:0] S2 = 7'b0100100;
   localparam logic [6:0] S3 = 7'b0110000;
   localparam logic [6:0] S4 = 7'b0011001;
   localparam logic [6:0] S5 = 7'b0010010;
   localparam logic [6:0] S6 = 7'b0000010;
   localparam logic [6:0] S7 = 7'b1111000;
   localparam logic [6:0] S8 = 7'b0000000;
   localparam logic [6:0] S9 = 7'b0010000;
   localparam logic [6:0] BL = 7'b1111111;

   logic        clock;
   logic        reset;
   logic [15:0] value;
   logic [6:0]  seg;
   logic [4:0]  anode;
   logic        negative;
   logic        busy;

   int n_chk  = 0;
   int n_pass = 0;

   result_display #(.SCAN_DIV(4)) dut (
      .clock    (clock),
      .reset    (reset),
      .value    (value),
      .seg      (seg),
      .anode    (anode),
      .negative (negative),
      .busy     (busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic check_disp(input string tag, input logic [6:0] e4,
                             input logic [6:0] e3, input logic [6:0] e2,
                             input logic [6:0] e1, input logic [6:0] e0);
      logic [6:0] exp_s [5];
      exp_s = '{e0, e1, e2, e3, e4};
      for (int k = 0; k < 5; k++) begin
         logic [4:0] want;
         int n;
         want = ~(5'b00001 << k);
         n = 0;
         while (anode !== want && n < 40) begin
            tick();
            n++;
         end
         check({tag, " anode"}, 32'(anode), 32'(want));
         check({tag, " seg"}, 32'(seg), 32'(exp_s[k]));
      end
   endtask

   task automatic convert(input string tag, input logic [15:0] v);
      value = v;
      tick();
      check({tag, " busy@0"}, 32'(busy), 32'd1);
      repeat (15) tick();
      check({tag, " busy@15"}, 32'(busy), 32'd1);
      tick();
      check({tag, " busy@16"}, 32'(busy), 32'd0);
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic busy_seen;
      logic exp_neg;
      reset = 1'b1;
      value = 16'd0;
      tick();
      tick();
      check("rst seg", 32'(seg), 32'(BL));
      check("rst anode", 32'(anode), 32'h1F);
      check("rst neg", 32'(negative), 32'd0);
      check("rst busy", 32'(busy), 32'd0);

      reset = 1'b0;
      tick();
      check("e1 anode", 32'(anode), 32'h1E);
      check("e1 seg", 32'(seg), 32'(S0));
      busy_seen = busy;
      repeat (4) begin
         tick();
         busy_seen = busy_seen | busy;
      end
      check("e5 anode", 32'(anode), 32'h1D);
      check("e5 seg", 32'(seg), 32'(BL));
      check("idle busy", 32'(busy_seen), 32'd0);

      convert("1234", 16'd1234);
      check("1234 digits", 32'(dut.r_digits), 32'h01234);
      check("1234 neg", 32'(negative), 32'd0);
      check_disp("1234", BL, S1, S2, S3, S4);

`ifdef RESULT_DISPLAY_SIGNED_EN
      exp_neg = 1'b1;
      convert("ffff", 16'hFFFF);
      check_disp("ffff", BL, BL, BL, BL, S1);
`else
      exp_neg = 1'b0;
      convert("ffff", 16'hFFFF);
      check_disp("ffff", S6, S5, S5, S3, S5);
`endif
      check("ffff neg", 32'(negative), 32'(exp_neg));

      convert("8000", 16'h8000);
      check_disp("8000", S3, S2, S7, S6, S8);
      check("8000 neg", 32'(negative), 32'(exp_neg));

      value = 16'd100;
      tick();
      check("100 busy", 32'(busy), 32'd1);
      repeat (5) tick();
      value = 16'd7;
      repeat (11) tick();
      check("100 done", 32'(busy), 32'd0);
      check("100 digits", 32'(dut.r_digits), 32'h00100);
      tick();
      check("7 busy@0", 32'(busy), 32'd1);
      repeat (15) tick();
      check("7 busy@15", 32'(busy), 32'd1);
      tick();
      check("7 busy@16", 32'(busy), 32'd0);
      check("7 digits", 32'(dut.r_digits), 32'h00007);
      check("7 neg", 32'(negative), 32'd0);

      value = 16'd999;
      tick();
      check("999 busy", 32'(busy), 32'd1);
      repeat (8) tick();
      reset = 1'b1;
      #1;
      check("abort busy", 32'(busy), 32'd0);
      check("abort digits", 32'(dut.r_digits), 32'h0);
      check("abort seg", 32'(seg), 32'(BL));
      tick();
      check("held digits", 32'(dut.r_digits), 32'h0);
      reset = 1'b0;
      repeat (16) tick();
      check("999 busy@16", 32'(busy), 32'd1);
      check("999 pre", 32'(dut.r_digits), 32'h0);
      tick();
      check("999 busy@17", 32'(busy), 32'd0);
      check("999 digits", 32'(dut.r_digits), 32'h00999);
      tick();
      check_disp("999", BL, BL, S9, S9, S9);

      convert("zero", 16'd0);
      check_disp("zero", BL, BL, BL, BL, S0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/result_display.md
# result_display

Output-side stage that takes the controller's 16-bit `outResult` word and shows it in decimal on a five-digit multiplexed seven-segment display. A change on the input starts a sequential binary-to-BCD conversion (shift-add-3, one bit per clock). The converted digits are latched, leading zeros are blanked, and the digits are time-multiplexed onto shared segment lines. It sits between `Controller.outResult` and the board display pins, in the same clock domain as the controller.

## Interface
- `SCAN_DIV`, default 16'd50000: clocks per digit slot; legal range 1..65535.
- `clock`  in  1: system clock; all state changes on its rising edge.
- `reset`  in  1: asynchronous, active-high; clears all state.
- `value`  in  16: word to display, normally `outResult`.
- `seg`  out  7: segments {g,f,e,d,c,b,a}, active-low, registered.
- `anode`  out  5: digit enables, one-hot active-low, registered; bit 0 is the units digit.
- `negative`  out  1: sign indicator, registered.
- `busy`  out  1: high while a conversion is running, registered.

## Operation
- Conversion FSM has two states: IDLE and CONV.
- IDLE: on an edge where `value != captured`, load `captured <= value`, clear the 20-bit BCD accumulator and the 4-bit step counter, and go to CONV. `busy` is 1 from that edge.
- CONV: each edge performs one step:
  - add 3 to every BCD nibble that is >= 5;
  - shift {bcd, shift_reg} left by 1.
- When the step counter reaches 15 (the 16th step), write the result into the digit latch `digits[4:0]`, clear `busy`, and return to IDLE.
- `value` changes during CONV are ignored. On return to IDLE, `value` is compared against `captured` again; a new difference starts a new conversion on the next edge.
- Leading-zero blanking: digit k (k >= 1) shows blank (7'b1111111) if it and every higher digit are 0. Digit 0 is never blanked.
- Segment codes for 0-9: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000.
- Scan:
  - `div_cnt` counts 0..SCAN_DIV-1 and wraps.
  - On the wrap edge, `scan_idx` advances 0..4 and then wraps to 0.
  - Every edge registers `anode <= ~(1 << scan_idx)` and `seg <= code(digits[scan_idx])`.
- The scan runs independently of conversion. The display shows the previous latched digits until a conversion completes.

## Timing
- Reset values:
  - `seg` = 7'b1111111, `anode` = 5'b11111, `negative` = 0, `busy` = 0;
  - `captured` = 0, `digits` = 0, `scan_idx` = 0, `div_cnt` = 0;
  - FSM = IDLE.
- First edge after reset deasserts: `anode` = 5'b11110, `seg` = 1000000 (shows "0").
- Latency: a change first seen at edge N gives `busy` high after N, the 16th step at N+16, and `digits`/`negative` updated at N+16. `seg` reflects the new digits from edge N+17. The minimum repeat interval is 17 edges.
- Reset asserted mid-conversion aborts immediately, with no partial latch. Because `captured` resets to 0, a nonzero `value` held through reset restarts conversion on the first edge after release.
- Digit slot length = SCAN_DIV clocks. One full frame = 5*SCAN_DIV clocks.
- SCAN_DIV = 1 advances `scan_idx` every edge.

## Configuration
- `RESULT_DISPLAY_SIGNED_EN` defined:
  - `captured` is treated as two's complement. At conversion start, if bit 15 is 1, the magnitude (~value + 1, 16-bit unsigned) is converted and `negative` is set at the latch edge; otherwise `negative` = 0.
  - 16'h8000 converts as 32768.
- Not defined:
  - `value` is unsigned (0..65535) and `negative` is tied 0.
  - No magnitude logic is present.

## Test plan
- Reset with SCAN_DIV=4 and `value`=0: outputs equal their reset values, then `anode` = 11110 with `seg` = 1000000. `busy` never rises. After 4 edges, `anode` = 11101 with `seg` blank.
- `value`=16'd1234 after reset: `busy` is high for 16 edges, then `digits` = {0,1,2,3,4}. The scan shows 4, 3, 2, 1 on anodes 0-3, and digit 4 is blank.
- Unsigned build, `value`=16'hFFFF: digits = 6,5,5,3,5 (65535), no blanking, `negative` = 0.
- Signed build:
  - `value`=16'hFFFF shows "1" with `negative` = 1 and digits 1-4 blank;
  - `value`=16'h8000 shows 32768 with `negative` = 1.
- `value`=100, then changed to 7 at step 5 of the conversion: the first result latches 100. A second conversion then starts on the following edge, and its result latches 7.
- `reset` pulsed at step 8 of the conversion of 999: `digits` stay 0 and `busy` = 0. After release, conversion restarts and latches 999, 17 edges after release.
